// File: rtl/fp_norm_pipe_pkg.sv
// Shared FPU normalizer types: count-width helper and the normalized-result record.
package fp_norm_pipe_pkg;

  localparam int unsigned FPU_MW = 53;
  localparam int unsigned FPU_EW = 13;

  // Width of a leading-zero count able to represent 0..mw inclusive.
  function automatic int unsigned norm_cnt_w(input int unsigned mw);
    return $clog2(mw + 1);
  endfunction

  localparam int unsigned FPU_CW = norm_cnt_w(FPU_MW);

  typedef struct packed {
    logic [FPU_MW-1:0] mant;
    logic [FPU_EW-1:0] exp;
    logic              zero;
    logic [FPU_CW-1:0] shamt;
  } norm_result_t;

endpackage

// File: rtl/fp_norm_pipe_lzc.sv
// Leading-zero counter: cnt_c = number of zeros above the highest set bit, WIDTH when in_i is zero.
module fp_norm_pipe_lzc
  import fp_norm_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 53,
  parameter int unsigned CW    = norm_cnt_w(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CW-1:0]    cnt_c
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt_c = CW'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (in_i[i]) cnt_c = CW'(int'(WIDTH) - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage normalizer: stage 1 registers operand and leading-zero count,
// stage 2 shifts the mantissa and adjusts the exponent, clamped at the subnormal boundary.
module fp_norm_pipe
  import fp_norm_pipe_pkg::*;
#(
  parameter int unsigned MW = 53,
  parameter int unsigned EW = 13,
  parameter int unsigned TW = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [MW-1:0]            in_mant_i,
  input  logic [EW-1:0]            in_exp_i,
  input  logic [TW-1:0]            in_tag_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [MW-1:0]            out_mant_o,
  output logic [EW-1:0]            out_exp_o,
  output logic                     out_zero_o,
  output logic [$clog2(MW+1)-1:0]  out_shamt_o,
  output logic [TW-1:0]            out_tag_o
);

  localparam int unsigned CW = norm_cnt_w(MW);
  localparam int unsigned XW = (EW > CW) ? EW : CW;

  typedef struct packed {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic          zero;
    logic [CW-1:0] shamt;
  } res_t;

  logic          s1_valid_q, s1_valid_d;
  logic [MW-1:0] s1_mant_q,  s1_mant_d;
  logic [EW-1:0] s1_exp_q,   s1_exp_d;
  logic [TW-1:0] s1_tag_q,   s1_tag_d;
  logic [CW-1:0] s1_cnt_q,   s1_cnt_d;
  logic          s1_zero_q,  s1_zero_d;

  logic          s2_valid_q, s2_valid_d;
  res_t          s2_res_q,   s2_res_d;
  logic [TW-1:0] s2_tag_q,   s2_tag_d;

  logic          s1_adv, s2_adv, s1_load, s2_load;
  logic [CW-1:0] lzc_cnt;
  logic [XW-1:0] exp_x, cnt_x;
  res_t          res_c;

  assign s2_adv     = ~s2_valid_q | out_ready_i;
  assign s1_adv     = ~s1_valid_q | s2_adv;
  assign s1_load    = s1_adv & in_valid_i;
  assign s2_load    = s2_adv & s1_valid_q;
  assign in_ready_o = s1_adv;

  fp_norm_pipe_lzc #(
    .WIDTH (MW),
    .CW    (CW)
  ) u_lzc (
    .in_i  (in_mant_i),
    .cnt_c (lzc_cnt)
  );

  // Stage 1: capture operand, count and zero flag; flush overrides any accept.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mant_d  = s1_mant_q;
    s1_exp_d   = s1_exp_q;
    s1_tag_d   = s1_tag_q;
    s1_cnt_d   = s1_cnt_q;
    s1_zero_d  = s1_zero_q;
    if (s1_adv) s1_valid_d = in_valid_i;
    if (s1_load) begin
      s1_mant_d = in_mant_i;
      s1_exp_d  = in_exp_i;
      s1_tag_d  = in_tag_i;
      s1_cnt_d  = lzc_cnt;
      s1_zero_d = (in_mant_i == '0);
    end
    if (flush_i) s1_valid_d = 1'b0;
  end

  // Shift amount never takes the exponent below 1, so exp - cnt cannot wrap.
  always_comb begin
    exp_x       = XW'(s1_exp_q);
    cnt_x       = XW'(s1_cnt_q);
    res_c.mant  = '0;
    res_c.exp   = '0;
    res_c.zero  = 1'b0;
    res_c.shamt = '0;
    if (s1_zero_q) begin
      res_c.zero = 1'b1;
    end else if (exp_x == '0) begin
      res_c.mant = s1_mant_q;
    end else if (cnt_x < exp_x) begin
      res_c.shamt = s1_cnt_q;
      res_c.exp   = EW'(exp_x - cnt_x);
      res_c.mant  = s1_mant_q << s1_cnt_q;
    end else begin
      res_c.shamt = CW'(exp_x - XW'(1));
      res_c.mant  = s1_mant_q << res_c.shamt;
    end
  end

  // Stage 2: result register feeding the outputs directly.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_tag_d   = s2_tag_q;
    if (s2_adv) s2_valid_d = s1_valid_q;
    if (s2_load) begin
      s2_res_d = res_c;
      s2_tag_d = s1_tag_q;
    end
    if (flush_i) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_tag_q   <= '0;
      s1_cnt_q   <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mant_q  <= s1_mant_d;
      s1_exp_q   <= s1_exp_d;
      s1_tag_q   <= s1_tag_d;
      s1_cnt_q   <= s1_cnt_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_mant_o  = s2_res_q.mant;
  assign out_exp_o   = s2_res_q.exp;
  assign out_zero_o  = s2_res_q.zero;
  assign out_shamt_o = s2_res_q.shamt;
  assign out_tag_o   = s2_tag_q;

endmodule
